pig_turn_ctrl: RTL and testbench
================================

Name: pig_turn_ctrl

Overview:
- Turn/score controller for the electronic pig game.
- Consumer end of the dice interface:
  - drives en_roll to the dice block while the player holds the roll button;
  - samples the settled 4-bit roll value;
  - applies pig rules for two players: a roll of 1 clears the turn total and passes the turn; 2..6 accumulates; hold banks the total.
- Sits between debounced button inputs and the score display/decoder logic.

Parameters:
- WIN_SCORE, 100, banked score at or above which the current player wins.
- SCORE_W, 7, width of score and turn_total registers.
- SETTLE_CYC, 8, clock cycles to wait after en_roll deasserts before sampling roll. Must exceed one dice-clock period.

Ports:
- clock  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- new_game  in  1  synchronous clear, single-cycle pulse.
- roll_btn  in  1  debounced roll button, level, synchronous to clock.
- hold_btn  in  1  debounced hold button, single-cycle pulse.
- roll  in  4  dice value from the dice block. Legal range 1..6.
- en_roll  out  1  registered enable to the dice block.
- cur_player  out  1  0 = player 0, 1 = player 1.
- turn_total  out  SCORE_W  points accumulated in the current turn.
- score0  out  SCORE_W  banked score, player 0.
- score1  out  SCORE_W  banked score, player 1.
- last_roll  out  4  last legal roll sampled.
- pig_out  out  1  one-cycle pulse when a 1 is rolled.
- bad_roll  out  1  one-cycle pulse when an illegal roll value is sampled.
- winner_valid  out  1  high once a player has won, until game clear.
- winner  out  1  winning player index.

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, state S_WAIT, settle counter 0.
- new_game: synchronous, highest priority in every state. Same clear as reset, next state S_WAIT.
- S_WAIT:
  - roll_btn=1 -> S_ROLL; en_roll goes 1 on that same edge.
  - else hold_btn=1 -> S_BANK.
  - If roll_btn and hold_btn are both high, roll wins and hold is dropped.
- S_ROLL:
  - en_roll=1 while roll_btn=1.
  - roll_btn=0 -> S_SETTLE; en_roll goes 0 on that edge; settle counter loads 0.
  - hold_btn is ignored.
- S_SETTLE:
  - Counter increments each cycle.
  - When it reaches SETTLE_CYC-1 -> S_EVAL.
  - All buttons ignored.
- S_EVAL (one cycle), sample roll:
  - roll==1: turn_total<=0, last_roll<=1, pig_out pulses, cur_player toggles.
  - roll in 2..6: last_roll<=roll; turn_total<=turn_total+roll, saturating at 2^SCORE_W-1.
  - roll==0 or roll>6: bad_roll pulses; turn_total, last_roll and cur_player unchanged.
  - Always -> S_WAIT next cycle.
- S_BANK (one cycle):
  - Score of cur_player <= score+turn_total, saturating at 2^SCORE_W-1.
  - turn_total<=0.
  - If the new score >= WIN_SCORE: winner<=cur_player, winner_valid<=1, cur_player unchanged, -> S_WIN.
  - Else cur_player toggles, -> S_WAIT.
  - Hold with turn_total=0 is legal and simply passes the turn.
- S_WIN: terminal. roll_btn and hold_btn ignored, en_roll=0. Exit only via new_game or reset.
- Pulse timing: pig_out and bad_roll are registered and high exactly one cycle, in the cycle after the S_EVAL edge.
- Latency: roll_btn release to turn_total update = SETTLE_CYC+1 cycles.
- Reset mid-roll: en_roll drops immediately, asynchronously.

Test Plan:
- Reset, then roll_btn high 20 cycles then low, roll=4 -> en_roll high for exactly 20 cycles; turn_total=4 and last_roll=4 at SETTLE_CYC+1 cycles after release; cur_player=0.
- Player 0 rolls 5 then 3, then hold pulse -> score0=8, turn_total=0, cur_player=1.
- Player 1 rolls 6, then rolls 1 -> pig_out pulses one cycle; turn_total=0; score1=0; cur_player=0; last_roll=1.
- Preload score0=95 via rolls/holds; player 0 rolls 6, then hold -> score0=101, winner_valid=1, winner=0; further roll_btn gives en_roll=0 and no state change; new_game clears everything.
- roll=0, then roll=9 at sample -> bad_roll pulses each time; turn_total and last_roll unchanged.
- roll_btn and hold_btn asserted in the same cycle in S_WAIT -> S_ROLL and en_roll=1, no bank. reset low mid-S_SETTLE -> all outputs 0 immediately.

Source files
------------

// File: rtl/pig_turn_ctrl.sv
// Turn and score controller for a two-player electronic pig game.
//
// Consumer end of the dice interface. While the player holds the roll button
// it drives en_roll to the dice block. After release it waits for the dice
// value to settle, then samples it and applies the pig rules:
//   - a 1 clears the turn total and passes the turn;
//   - 2..6 adds to the turn total;
//   - hold banks the turn total into the current player's score.
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-low reset
//   new_game     synchronous clear pulse, overrides everything
//   roll_btn     debounced roll button (level)
//   hold_btn     debounced hold button (single-cycle pulse)
//   roll         dice value from the dice block, legal range 1..6
//   en_roll      registered enable to the dice block
//   cur_player   player whose turn it is (0 or 1)
//   turn_total   points accumulated in the current turn
//   score0/1     banked scores
//   last_roll    last legal roll sampled
//   pig_out      one-cycle pulse when a 1 is rolled
//   bad_roll     one-cycle pulse when an illegal dice value is sampled
//   winner_valid high once a player has won, until cleared
//   winner       index of the winning player
module pig_turn_ctrl #(
  parameter int WIN_SCORE  = 100,
  parameter int SCORE_W    = 7,
  parameter int SETTLE_CYC = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               new_game,
  input  logic               roll_btn,
  input  logic               hold_btn,
  input  logic [3:0]         roll,
  output logic               en_roll,
  output logic               cur_player,
  output logic [SCORE_W-1:0] turn_total,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic [3:0]         last_roll,
  output logic               pig_out,
  output logic               bad_roll,
  output logic               winner_valid,
  output logic               winner
);

  // The counter only has to hold 0..SETTLE_CYC-1.
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    S_WAIT, S_ROLL, S_SETTLE, S_EVAL, S_BANK, S_WIN
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               en_nx, cp_nx, pig_nx, bad_nx, wv_nx, w_nx;
  logic [SCORE_W-1:0] tt_nx, s0_nx, s1_nx, bank_score;
  logic [3:0]         lr_nx;

  // Adds two scores, clamping at the all-ones maximum instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

  function automatic logic is_scoring(input logic [3:0] v);
    return (v >= 4'd2) && (v <= 4'd6);
  endfunction

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    en_nx      = en_roll;
    cp_nx      = cur_player;
    tt_nx      = turn_total;
    s0_nx      = score0;
    s1_nx      = score1;
    lr_nx      = last_roll;
    pig_nx     = 1'b0;
    bad_nx     = 1'b0;
    wv_nx      = winner_valid;
    w_nx       = winner;
    bank_score = sat_add(cur_player ? score1 : score0, turn_total);

    if (new_game) begin
      state_nx = S_WAIT;
      cnt_nx   = '0;
      en_nx    = 1'b0;
      cp_nx    = 1'b0;
      tt_nx    = '0;
      s0_nx    = '0;
      s1_nx    = '0;
      lr_nx    = '0;
      wv_nx    = 1'b0;
      w_nx     = 1'b0;
    end else begin
      unique case (state)
        S_WAIT: begin
          // Roll takes precedence; a simultaneous hold is dropped.
          if (roll_btn) begin
            state_nx = S_ROLL;
            en_nx    = 1'b1;
          end else if (hold_btn) begin
            state_nx = S_BANK;
          end
        end
        S_ROLL: begin
          if (!roll_btn) begin
            state_nx = S_SETTLE;
            en_nx    = 1'b0;
            cnt_nx   = '0;
          end
        end
        S_SETTLE: begin
          // Give the dice block time to present a stable value.
          if (cnt == CNT_W'(SETTLE_CYC - 1)) state_nx = S_EVAL;
          else                               cnt_nx   = cnt + CNT_W'(1);
        end
        S_EVAL: begin
          state_nx = S_WAIT;
          if (roll == 4'd1) begin
            tt_nx  = '0;
            lr_nx  = 4'd1;
            pig_nx = 1'b1;
            cp_nx  = ~cur_player;
          end else if (is_scoring(roll)) begin
            lr_nx = roll;
            tt_nx = sat_add(turn_total, SCORE_W'(roll));
          end else begin
            bad_nx = 1'b1;
          end
        end
        S_BANK: begin
          tt_nx = '0;
          if (cur_player) s1_nx = bank_score;
          else            s0_nx = bank_score;
          if (int'(bank_score) >= WIN_SCORE) begin
            wv_nx    = 1'b1;
            w_nx     = cur_player;
            state_nx = S_WIN;
          end else begin
            cp_nx    = ~cur_player;
            state_nx = S_WAIT;
          end
        end
        S_WIN: begin
          en_nx = 1'b0;
        end
        default: state_nx = S_WAIT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_WAIT;
      cnt          <= '0;
      en_roll      <= 1'b0;
      cur_player   <= 1'b0;
      turn_total   <= '0;
      score0       <= '0;
      score1       <= '0;
      last_roll    <= '0;
      pig_out      <= 1'b0;
      bad_roll     <= 1'b0;
      winner_valid <= 1'b0;
      winner       <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      en_roll      <= en_nx;
      cur_player   <= cp_nx;
      turn_total   <= tt_nx;
      score0       <= s0_nx;
      score1       <= s1_nx;
      last_roll    <= lr_nx;
      pig_out      <= pig_nx;
      bad_roll     <= bad_nx;
      winner_valid <= wv_nx;
      winner       <= w_nx;
    end
  end

endmodule

// File: tb/tb_pig_turn_ctrl.sv
// Testbench for pig_turn_ctrl: a table of game moves with expected scores,
// hand-written corner-case sequences, and a randomized game checked against
// a behavioural model of the pig rules.
module tb_pig_turn_ctrl;

  localparam int SW   = 7;
  localparam int SET  = 8;
  localparam int WIN  = 100;
  localparam int MAXS = 127;

  localparam int OP_ROLL = 0;
  localparam int OP_HOLD = 1;
  localparam int OP_NEW  = 2;

  logic          clock    = 1'b0;
  logic          reset    = 1'b0;
  logic          new_game = 1'b0;
  logic          roll_btn = 1'b0;
  logic          hold_btn = 1'b0;
  logic [3:0]    roll     = 4'd0;
  logic          en_roll, cur_player, pig_out, bad_roll, winner_valid, winner;
  logic [SW-1:0] turn_total, score0, score1;
  logic [3:0]    last_roll;

  pig_turn_ctrl #(.WIN_SCORE(WIN), .SCORE_W(SW), .SETTLE_CYC(SET)) dut (
    .clock(clock), .reset(reset), .new_game(new_game), .roll_btn(roll_btn),
    .hold_btn(hold_btn), .roll(roll), .en_roll(en_roll), .cur_player(cur_player),
    .turn_total(turn_total), .score0(score0), .score1(score1),
    .last_roll(last_roll), .pig_out(pig_out), .bad_roll(bad_roll),
    .winner_valid(winner_valid), .winner(winner)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int en_cnt, pig_cnt, bad_cnt, pig_at, bad_at, tt_before;

  typedef struct {
    int op; int v; int n;
    int tt; int s0; int s1; int cp; int lr; int pig; int bd; int wv; int w;
  } vec_t;
  vec_t vecs[$];

  // Behavioural model of the game.
  int m_score[2];
  int m_tt, m_cp, m_lr, m_won, m_w;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int tt, input int s0,
                             input int s1, input int cp, input int lr,
                             input int wv, input int w);
    check({tag, ".turn_total"},   int'(turn_total),   tt);
    check({tag, ".score0"},       int'(score0),       s0);
    check({tag, ".score1"},       int'(score1),       s1);
    check({tag, ".cur_player"},   int'(cur_player),   cp);
    check({tag, ".last_roll"},    int'(last_roll),    lr);
    check({tag, ".winner_valid"}, int'(winner_valid), wv);
    check({tag, ".winner"},       int'(winner),       w);
  endtask

  // Holds roll_btn for n cycles, releases, and waits through settle, sample,
  // and one extra cycle so pulse widths can be counted.
  task automatic do_roll(input int v, input int n);
    roll     = v[3:0];
    roll_btn = 1'b1;
    en_cnt   = 0;
    pig_cnt  = 0;
    bad_cnt  = 0;
    for (int i = 0; i < n; i++) begin
      tick;
      en_cnt += int'(en_roll);
    end
    roll_btn = 1'b0;
    for (int i = 0; i <= SET + 1; i++) begin
      tick;
      en_cnt  += int'(en_roll);
      pig_cnt += int'(pig_out);
      bad_cnt += int'(bad_roll);
      if (i == SET) tt_before = int'(turn_total);
    end
    pig_at = int'(pig_out);
    bad_at = int'(bad_roll);
    tick;
    pig_cnt += int'(pig_out);
    bad_cnt += int'(bad_roll);
  endtask

  task automatic do_hold;
    hold_btn = 1'b1;
    tick;
    hold_btn = 1'b0;
    tick;
    tick;
  endtask

  task automatic do_new;
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    tick;
  endtask

  function automatic void add(input int op, input int v, input int n,
                              input int tt, input int s0, input int s1,
                              input int cp, input int lr, input int pig,
                              input int bd, input int wv, input int w);
    vec_t r;
    r.op = op; r.v = v; r.n = n; r.tt = tt; r.s0 = s0; r.s1 = s1;
    r.cp = cp; r.lr = lr; r.pig = pig; r.bd = bd; r.wv = wv; r.w = w;
    vecs.push_back(r);
  endfunction

  function automatic void model_clear;
    m_score[0] = 0; m_score[1] = 0;
    m_tt = 0; m_cp = 0; m_lr = 0; m_won = 0; m_w = 0;
  endfunction

  initial begin
    int prev_tt, exp_pig, exp_bad;
    string tag;

    // ---- move table ----
    add(OP_ROLL, 4, 20,  4,  0, 0, 0, 4, 0, 0, 0, 0);
    add(OP_NEW,  0, 0,   0,  0, 0, 0, 0, 0, 0, 0, 0);
    add(OP_ROLL, 5, 3,   5,  0, 0, 0, 5, 0, 0, 0, 0);
    add(OP_ROLL, 3, 2,   8,  0, 0, 0, 3, 0, 0, 0, 0);
    add(OP_HOLD, 0, 0,   0,  8, 0, 1, 3, 0, 0, 0, 0);
    add(OP_ROLL, 6, 4,   6,  8, 0, 1, 6, 0, 0, 0, 0);
    add(OP_ROLL, 1, 2,   0,  8, 0, 0, 1, 1, 0, 0, 0);
    add(OP_ROLL, 2, 1,   2,  8, 0, 0, 2, 0, 0, 0, 0);
    add(OP_ROLL, 0, 3,   2,  8, 0, 0, 2, 0, 1, 0, 0);
    add(OP_ROLL, 9, 3,   2,  8, 0, 0, 2, 0, 1, 0, 0);
    add(OP_ROLL, 15, 2,  2,  8, 0, 0, 2, 0, 1, 0, 0);
    add(OP_HOLD, 0, 0,   0, 10, 0, 1, 2, 0, 0, 0, 0);
    add(OP_HOLD, 0, 0,   0, 10, 0, 0, 2, 0, 0, 0, 0);
    for (int k = 1; k <= 13; k++)
      add(OP_ROLL, 6, 1, 6 * k, 10, 0, 0, 6, 0, 0, 0, 0);
    add(OP_ROLL, 5, 1,  83, 10, 0, 0, 5, 0, 0, 0, 0);
    add(OP_ROLL, 2, 1,  85, 10, 0, 0, 2, 0, 0, 0, 0);
    add(OP_HOLD, 0, 0,   0, 95, 0, 1, 2, 0, 0, 0, 0);
    add(OP_HOLD, 0, 0,   0, 95, 0, 0, 2, 0, 0, 0, 0);
    add(OP_ROLL, 6, 2,   6, 95, 0, 0, 6, 0, 0, 0, 0);
    add(OP_HOLD, 0, 0,   0, 101, 0, 0, 6, 0, 0, 1, 0);
    add(OP_ROLL, 3, 5,   0, 101, 0, 0, 6, 0, 0, 1, 0);
    add(OP_HOLD, 0, 0,   0, 101, 0, 0, 6, 0, 0, 1, 0);
    add(OP_NEW,  0, 0,   0,  0, 0, 0, 0, 0, 0, 0, 0);

    // ---- reset ----
    repeat (3) tick;
    check("rst.en_roll",  int'(en_roll),  0);
    check("rst.pig_out",  int'(pig_out),  0);
    check("rst.bad_roll", int'(bad_roll), 0);
    check_state("rst", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick;

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      tag     = $sformatf("vec%0d", i);
      prev_tt = int'(turn_total);
      if (vecs[i].op == OP_ROLL) begin
        do_roll(vecs[i].v, vecs[i].n);
        check({tag, ".en_cycles"}, en_cnt, (vecs[i].wv != 0) ? 0 : vecs[i].n);
        check({tag, ".tt_latency"}, tt_before, prev_tt);
        check({tag, ".pig_at"},  pig_at,  vecs[i].pig);
        check({tag, ".pig_len"}, pig_cnt, vecs[i].pig);
        check({tag, ".bad_at"},  bad_at,  vecs[i].bd);
        check({tag, ".bad_len"}, bad_cnt, vecs[i].bd);
      end else if (vecs[i].op == OP_HOLD) begin
        do_hold;
      end else begin
        do_new;
      end
      check_state(tag, vecs[i].tt, vecs[i].s0, vecs[i].s1, vecs[i].cp,
                  vecs[i].lr, vecs[i].wv, vecs[i].w);
    end

    // ---- roll and hold together in S_WAIT: roll wins ----
    roll     = 4'd3;
    roll_btn = 1'b1;
    hold_btn = 1'b1;
    tick;
    hold_btn = 1'b0;
    check("both.en_roll", int'(en_roll), 1);
    repeat (3) tick;
    roll_btn = 1'b0;
    repeat (SET + 3) tick;
    check_state("both", 3, 0, 0, 0, 3, 0, 0);

    // ---- turn total saturates, then a saturated bank wins ----
    do_new;
    for (int k = 0; k < 22; k++) do_roll(6, 1);
    check("sat.turn_total", int'(turn_total), MAXS);
    do_hold;
    check_state("satbank", 0, MAXS, 0, 0, 6, 1, 0);
    do_new;

    // ---- asynchronous reset in the middle of a roll ----
    do_roll(5, 2);
    do_hold;
    roll     = 4'd4;
    roll_btn = 1'b1;
    repeat (3) tick;
    roll_btn = 1'b0;
    repeat (3) tick;
    #2 reset = 1'b0;
    #1;
    check("rst_settle.en_roll", int'(en_roll), 0);
    check_state("rst_settle", 0, 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    tick;
    roll_btn = 1'b1;
    repeat (2) tick;
    check("pre_rst_roll.en_roll", int'(en_roll), 1);
    #2 reset = 1'b0;
    #1;
    check("rst_roll.en_roll", int'(en_roll), 0);
    roll_btn = 1'b0;
    #1 reset = 1'b1;
    tick;

    // ---- randomized game against the model ----
    do_new;
    model_clear();
    for (int i = 0; i < 220; i++) begin
      int r, v, n, s;
      tag = $sformatf("rnd%0d", i);
      r   = int'($urandom_range(0, 99));
      exp_pig = 0;
      exp_bad = 0;
      if (m_won != 0 && r < 30) begin
        do_new;
        model_clear();
      end else if (r < 30) begin
        do_hold;
        if (m_won == 0) begin
          s = m_score[m_cp] + m_tt;
          m_score[m_cp] = (s > MAXS) ? MAXS : s;
          m_tt = 0;
          if (m_score[m_cp] >= WIN) begin
            m_won = 1;
            m_w   = m_cp;
          end else begin
            m_cp = 1 - m_cp;
          end
        end
      end else begin
        v = (($urandom_range(0, 9)) < 8) ? int'($urandom_range(1, 6))
                                          : int'($urandom_range(0, 15));
        n = int'($urandom_range(1, 4));
        do_roll(v, n);
        if (m_won == 0) begin
          if (v == 1) begin
            m_tt = 0; m_lr = 1; m_cp = 1 - m_cp; exp_pig = 1;
          end else if (v >= 2 && v <= 6) begin
            m_tt = (m_tt + v > MAXS) ? MAXS : m_tt + v;
            m_lr = v;
          end else begin
            exp_bad = 1;
          end
        end
        check({tag, ".en_cycles"}, en_cnt, (m_won != 0) ? 0 : n);
        check({tag, ".pig_len"}, pig_cnt, exp_pig);
        check({tag, ".bad_len"}, bad_cnt, exp_bad);
      end
      check_state(tag, m_tt, m_score[0], m_score[1], m_cp, m_lr, m_won, m_w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
